adder_err_sweep: RTL and testbench
==================================

// Module: adder_err_sweep
// PURPOSE
//  Exhaustive error-evaluation harness for the approximate adder netlists.
//  Drives every input vector into an approximate adder, samples its sum, and
//  compares it against the exact sum.
//  Reports max absolute error, worst vector and error-threshold violations.
//  This is the checker at the consumer end of the adder's in*/out* interface.
// PARAMETERS
//  IN_W   4  total adder input bits; operand A = stim[IN_W/2-1:0], B = stim[IN_W-1:IN_W/2]
//  OUT_W  3  adder output width; must equal IN_W/2+1
//  ET     5  error threshold; a vector violates when |exact-approx| > ET
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  start      in   1          begin sweep; sampled only in IDLE
//  stim       out  IN_W       vector driven to adder inputs (in0 = stim[0])
//  approx_out in   OUT_W      adder outputs (out0 = bit 0), combinational from stim
//  busy       out  1          sweep in progress
//  done       out  1          level; results valid; cleared on next accepted start
//  pass       out  1          1 when viol_cnt == 0; valid while done
//  max_err    out  OUT_W      largest |exact-approx| seen
//  worst_vec  out  IN_W       first stim value that produced max_err
//  viol_cnt   out  IN_W+1     number of vectors with error > ET
//  err_sum    out  IN_W+OUT_W sum of |exact-approx| over all vectors (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (stim, busy, done, pass, max_err, worst_vec,
//   viol_cnt, err_sum). Reset mid-sweep aborts immediately; no partial results kept.
//  FSM states: IDLE, DRIVE, CHECK, DONE.
//   IDLE : start=1 -> DRIVE; stim<=0; clear all result registers; busy<=1; done<=0.
//   DRIVE: settle cycle; stim held -> CHECK.
//   CHECK: exact = A+B (OUT_W bits, zero-extended operands).
//    err = exact>=approx_out ? exact-approx_out : approx_out-exact.
//    err > max_err (strict) -> max_err<=err, worst_vec<=stim.
//    err > ET -> viol_cnt++.
//    If stim == all-ones -> DONE; else stim++ and return to DRIVE.
//   DONE : busy=0; done=1; pass=(viol_cnt==0); stim holds all-ones.
//    start=1 -> same as IDLE start (clears and restarts).
//  start while busy is ignored. Counters never wrap: viol_cnt max 2^IN_W.
//  Timing: busy rises on the edge that accepts start.
//   done rises 2*2^IN_W cycles later (32 for IN_W=4).
//  Results update only in CHECK. Outputs are registered; no combinational path
//   from approx_out to any output.
// CONFIGURATION
//  ADDER_ERR_SUM_EN defined: err_sum accumulates err in every CHECK.
//   It is cleared on start and never saturates at the chosen width.
//  ADDER_ERR_SUM_EN undefined: no accumulator logic is built; err_sum tied to 0.
//  All other behaviour is identical in both builds.
// TESTING (IN_W=4, OUT_W=3, ET=5)
//  1. Exact adder model, start pulse -> done after 32 cycles;
//     max_err=0, viol_cnt=0, pass=1, worst_vec=0.
//  2. approx_out stuck 0 -> max_err=6, worst_vec=4'hF, viol_cnt=1, pass=0;
//     err_sum=48 with ADDER_ERR_SUM_EN, 0 without.
//  3. approx_out stuck 7 -> max_err=7, worst_vec=4'h0, viol_cnt=3, pass=0.
//  4. start re-pulsed at cycle 10 of sweep -> ignored; done still at cycle 32, same results.
//  5. rst asserted async at stim=4'h7 -> same cycle busy=0 and all outputs 0; FSM=IDLE.
//     Next start runs a full clean sweep.
//  6. From DONE, start with exact model after failing run -> done drops next edge;
//     after 32 cycles pass=1, viol_cnt=0.

Source files
------------

// File: rtl/adder_err_sweep.sv
// Exhaustive error sweep of an approximate adder: drives every stim vector,
// compares the returned sum against A+B. Optional macro ADDER_ERR_SUM_EN builds the err_sum accumulator.
module adder_err_sweep #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 3,
  parameter int ET    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [IN_W-1:0]         stim,
  input  logic [OUT_W-1:0]        approx_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [OUT_W-1:0]        max_err,
  output logic [IN_W-1:0]         worst_vec,
  output logic [IN_W:0]           viol_cnt,
  output logic [IN_W+OUT_W-1:0]   err_sum
);

  localparam int          HW   = IN_W / 2;
  localparam int          SW   = IN_W + OUT_W;
  localparam logic [31:0] ET_L = 32'(ET);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [OUT_W-1:0]  max_q, max_d;
  logic [IN_W-1:0]   worst_q, worst_d;
  logic [IN_W:0]     viol_q, viol_d;
  logic [OUT_W-1:0]  exact, err;

`ifdef ADDER_ERR_SUM_EN
  logic [SW-1:0]     sum_q, sum_d;
`endif

  assign exact = OUT_W'(stim_q[HW-1:0]) + OUT_W'(stim_q[IN_W-1:HW]);
  assign err   = (exact >= approx_out) ? exact - approx_out : approx_out - exact;

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    max_d   = max_q;
    worst_d = worst_q;
    viol_d  = viol_q;
`ifdef ADDER_ERR_SUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          stim_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          max_d   = '0;
          worst_d = '0;
          viol_d  = '0;
`ifdef ADDER_ERR_SUM_EN
          sum_d   = '0;
`endif
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (err > max_q) begin
          max_d   = err;
          worst_d = stim_q;
        end
        if (32'(err) > ET_L) viol_d = viol_q + 1'b1;
`ifdef ADDER_ERR_SUM_EN
        sum_d = sum_q + SW'(err);
`endif
        // pass is taken from the count including this final vector
        if (stim_q == '1) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (viol_d == '0);
        end else begin
          stim_d  = stim_q + 1'b1;
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      max_q   <= '0;
      worst_q <= '0;
      viol_q  <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      max_q   <= max_d;
      worst_q <= worst_d;
      viol_q  <= viol_d;
    end
  end

`ifdef ADDER_ERR_SUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end
  assign err_sum = sum_q;
`else
  assign err_sum = '0;
`endif

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign max_err   = max_q;
  assign worst_vec = worst_q;
  assign viol_cnt  = viol_q;

endmodule

// File: tb/tb_adder_err_sweep.sv
// Directed + randomized bench for adder_err_sweep; the adder under test is a
// lookup table indexed by stim, and expected results come from a vector loop.
module tb_adder_err_sweep;
  localparam int IN_W  = 4;
  localparam int OUT_W = 3;
  localparam int ET    = 5;
  localparam int NV    = 1 << IN_W;
  localparam int HW    = IN_W / 2;

  typedef logic [31:0] w32_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [IN_W-1:0]       stim;
  logic [OUT_W-1:0]      approx_out;
  logic                  busy, done, pass;
  logic [OUT_W-1:0]      max_err;
  logic [IN_W-1:0]       worst_vec;
  logic [IN_W:0]         viol_cnt;
  logic [IN_W+OUT_W-1:0] err_sum;

  logic [OUT_W-1:0] lut [NV];
  int errors = 0;
  int checks = 0;
  int exp_max, exp_worst, exp_viol, exp_sum;

  always #5 clk = ~clk;
  assign approx_out = lut[stim];

  adder_err_sweep #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .approx_out(approx_out),
    .busy(busy), .done(done), .pass(pass), .max_err(max_err),
    .worst_vec(worst_vec), .viol_cnt(viol_cnt), .err_sum(err_sum)
  );

  task automatic chk(input string tag, input w32_t obs, input w32_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_exact();
    for (int v = 0; v < NV; v++) lut[v] = OUT_W'((v % (1 << HW)) + (v >> HW));
  endtask

  task automatic set_const(input int k);
    for (int v = 0; v < NV; v++) lut[v] = OUT_W'(k);
  endtask

  task automatic set_random();
    for (int v = 0; v < NV; v++) lut[v] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
  endtask

  task automatic model();
    exp_max = 0; exp_worst = 0; exp_viol = 0; exp_sum = 0;
    for (int v = 0; v < NV; v++) begin
      int ex, ap, e;
      ex = (v % (1 << HW)) + (v >> HW);
      ap = int'(lut[v]);
      e  = (ex >= ap) ? ex - ap : ap - ex;
      if (e > exp_max) begin exp_max = e; exp_worst = v; end
      if (e > ET) exp_viol++;
      exp_sum += e;
    end
`ifndef ADDER_ERR_SUM_EN
    exp_sum = 0;
`endif
  endtask

  // Accept a start, optionally re-pulse it mid-sweep, then check timing and results.
  task automatic run_sweep(input string tag, input int repulse_at);
    int n;
    model();
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    chk({tag, "_busy_on"}, w32_t'(busy), 1);
    chk({tag, "_done_off"}, w32_t'(done), 0);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk) #1;
      n++;
      start = (n == repulse_at);
    end
    start = 1'b0;
    chk({tag, "_cycles"}, w32_t'(n), 2 * NV);
    chk({tag, "_busy_off"}, w32_t'(busy), 0);
    chk({tag, "_stim"}, w32_t'(stim), NV - 1);
    chk({tag, "_max"}, w32_t'(max_err), w32_t'(exp_max));
    chk({tag, "_worst"}, w32_t'(worst_vec), w32_t'(exp_worst));
    chk({tag, "_viol"}, w32_t'(viol_cnt), w32_t'(exp_viol));
    chk({tag, "_pass"}, w32_t'(pass), w32_t'(exp_viol == 0));
    chk({tag, "_sum"}, w32_t'(err_sum), w32_t'(exp_sum));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim"}, w32_t'(stim), 0);
    chk({tag, "_busy"}, w32_t'(busy), 0);
    chk({tag, "_done"}, w32_t'(done), 0);
    chk({tag, "_pass"}, w32_t'(pass), 0);
    chk({tag, "_max"}, w32_t'(max_err), 0);
    chk({tag, "_worst"}, w32_t'(worst_vec), 0);
    chk({tag, "_viol"}, w32_t'(viol_cnt), 0);
    chk({tag, "_sum"}, w32_t'(err_sum), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    set_exact();
    #12;
    chk_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start_busy", w32_t'(busy), 0);

    run_sweep("exact", -1);
    set_const(0);
    run_sweep("stuck0", -1);
    set_exact();
    run_sweep("restart_from_fail", -1);
    set_const(7);
    run_sweep("stuck7_repulse", 10);

    // Abort mid-sweep with a faulty adder so partial results are nonzero.
    set_const(0);
    @(negedge clk) start = 1'b1;
    @(posedge clk) #1 start = 1'b0;
    k = 0;
    while (stim != 4'h7 && k < 40) begin
      @(posedge clk) #1;
      k++;
    end
    chk("abort_reach7", w32_t'(stim), 7);
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge clk) rst = 1'b0;
    set_exact();
    run_sweep("after_abort", -1);

    for (int r = 0; r < 4; r++) begin
      set_random();
      run_sweep($sformatf("rand%0d", r), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
